packer_mlane: RTL and testbench
===============================

# packer_mlane

Multi-lane successor to the single-word packer. It collects a run-time count of 1..NUM_DATA words, LANES words per input beat, into one wide word and presents it with a valid/ready output handshake. It sits between an on-chip buffer reader (ReqDat/ValDat side) and the PE-array loader (OutVal/OutRdy side). The result is held until consumed.

## Interface
- DATA_WIDTH, 8, bits per word
- NUM_DATA, 32, maximum words per packed output; must be a multiple of LANES
- LANES, 4, words delivered per input beat; power of two, ≥1

- clk  in  1  clock
- rst  in  1  reset; one clock domain, synchronous, active-high
- Sta  in  1  start pulse; sampled only in IDLE
- Bypass  in  1  pulse; produce an all-zero output with no fetch; beats Sta in IDLE
- NumPacker  in  $clog2(NUM_DATA)+1  word count, sampled with Sta
- ReqDat  out  1  one beat requested per asserted cycle
- ValDat  in  1  beat valid; arrives ≥1 cycle after its ReqDat, in order
- Dat  in  DATA_WIDTH*LANES  lane i at [i*DATA_WIDTH +: DATA_WIDTH]; lane 0 is the earliest word
- DatPacker  out  DATA_WIDTH*NUM_DATA  packed result
- OutVal  out  1  DatPacker valid
- OutRdy  in  1  consumer accepts DatPacker
- NearFnhPacker  out  1  combinational; high in the cycle the final beat is accepted, or when Bypass is accepted

## Operation
- States: IDLE, FILL, DONE.
- IDLE, Bypass=1:
  - Next state DONE.
  - DatPacker cleared to 0.
- IDLE, Sta=1, Bypass=0:
  - Latch Need = NumPacker, clamped to NUM_DATA.
  - Need=0 is handled as Bypass.
  - Clear DatPacker, ReqCnt and FillCnt.
  - Next state FILL.
- FILL:
  - ReqDat = (ReqCnt < ceil(Need/LANES)). ReqCnt increments on each ReqDat.
  - On ValDat, accept k = min(LANES, Need−FillCnt) words, taken from lanes 0..k−1.
  - Shift DatPacker left by k*DATA_WIDTH and insert lane 0 highest, lane k−1 lowest.
  - FillCnt += k.
  - When FillCnt+k == Need: assert NearFnhPacker and go to DONE.
- DONE:
  - OutVal=1 and DatPacker is frozen.
  - On OutVal&&OutRdy, go to IDLE.
- Final layout (default order):
  - Word 0 at [Need*W−1 -: W], word Need−1 at [W−1:0].
  - Bits above Need*W are zero.
- Ignored inputs:
  - Sta and Bypass outside IDLE.
  - ValDat in IDLE or DONE.
  - ValDat beyond the requested beats.
  - Upper lanes of a partial last beat.
- Widths: FillCnt and ReqCnt are $clog2(NUM_DATA)+1 bits. Beat count is ceil(Need/LANES) ≤ NUM_DATA/LANES. No wrap is possible.

## Timing
- Reset values: DatPacker=0, OutVal=0, ReqDat=0, NearFnhPacker=0, state IDLE. Counters are 0.
- Reset mid-FILL or mid-DONE:
  - Aborts the run.
  - ValDat of outstanding requests after reset is ignored.
- Sta at cycle t: ReqDat is high from t+1 for ceil(Need/LANES) consecutive cycles. There is no bubble.
- Final ValDat at cycle c: NearFnhPacker high at c, OutVal and final DatPacker at c+1.
- Bypass at cycle t: NearFnhPacker high at t, OutVal=1 with DatPacker=0 at t+1. ReqDat is never asserted.
- OutVal&&OutRdy at cycle d: OutVal=0 and state IDLE at d+1. Sta is accepted from d+1.
- Minimum turnaround with 1-cycle ValDat latency and OutRdy tied high: ceil(Need/LANES)+3 cycles from Sta to the next accepted Sta.

## Configuration
- PACKER_MLANE_LSB_FIRST_EN, defined:
  - Word j goes to [j*W +: W].
  - Word 0 is at the LSB and the register fills upward.
  - Unfilled upper bits stay zero.
- Undefined (default): MSB-first shift-left order as described in Operation.
- The macro does not change handshakes, latencies or counters.

## Test plan
- W=8, NUM_DATA=32, LANES=4. NumPacker=8 with beats {01,02,03,04} and {05,06,07,08} (lane 0 first) -> DatPacker[63:0]=0x0102030405060708, upper bits 0, OutVal one cycle after the 2nd ValDat. With PACKER_MLANE_LSB_FIRST_EN -> 0x0807060504030201.
- NumPacker=6 with beats {11,12,13,14} and {15,16,AA,BB} -> ReqDat high exactly 2 cycles, DatPacker=0x111213141516, AA/BB discarded.
- Bypass pulse in IDLE -> NearFnhPacker same cycle, OutVal=1 with DatPacker=0 next cycle, ReqDat stays 0.
- NumPacker=32, ValDat 1 cycle after each ReqDat -> 8 back-to-back ReqDat; OutVal at Sta+10.
- OutRdy held low 5 cycles in DONE with a Sta pulse injected -> OutVal and DatPacker stable, Sta ignored. The next Sta after the handshake starts normally.
- rst asserted after 3 of 8 beats, with stale ValDat afterwards -> all outputs 0 and IDLE. The next run with NumPacker=4 yields 0xXXXXXXXX of its own beat only, with no stale words.

Source files
------------

// File: rtl/packer_mlane_if.sv
// Handshake/data bundle between the buffer reader, packer_mlane and the PE-array loader.
interface packer_mlane_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_DATA   = 32,
    parameter int LANES      = 4
);
    localparam int CW = $clog2(NUM_DATA) + 1;

    logic                           Sta;
    logic                           Bypass;
    logic [CW-1:0]                  NumPacker;
    logic                           ReqDat;
    logic                           ValDat;
    logic [DATA_WIDTH*LANES-1:0]    Dat;
    logic [DATA_WIDTH*NUM_DATA-1:0] DatPacker;
    logic                           OutVal;
    logic                           OutRdy;
    logic                           NearFnhPacker;

    modport master (
        output Sta, Bypass, NumPacker, ValDat, Dat, OutRdy,
        input  ReqDat, DatPacker, OutVal, NearFnhPacker
    );

    modport slave (
        input  Sta, Bypass, NumPacker, ValDat, Dat, OutRdy,
        output ReqDat, DatPacker, OutVal, NearFnhPacker
    );
endinterface

// File: rtl/packer_mlane.sv
// Multi-lane word packer: gathers 1..NUM_DATA words, LANES per beat, into one wide word.
// Define PACKER_MLANE_LSB_FIRST_EN to place word 0 at the LSB instead of MSB-first order.
module packer_mlane #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_DATA   = 32,
    parameter int LANES      = 4
) (
    input  logic          clk,
    input  logic          rst,
    packer_mlane_if.slave bus
);
    localparam int CW = $clog2(NUM_DATA) + 1;
    localparam int PW = DATA_WIDTH * NUM_DATA;
    localparam int LW = $clog2(LANES);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] need_q, need_d;
    logic [CW-1:0] req_cnt_q, req_cnt_d;
    logic [CW-1:0] fill_cnt_q, fill_cnt_d;
    logic [PW-1:0] dat_q, dat_d;
    logic [PW-1:0] packed_next;
    logic [CW-1:0] need_in, beats, remain, take;
    logic [CW:0]   need_rnd;

    assign need_in  = (bus.NumPacker > CW'(NUM_DATA)) ? CW'(NUM_DATA) : bus.NumPacker;
    assign need_rnd = {1'b0, need_q} + (CW+1)'(LANES - 1);
    assign beats    = CW'(need_rnd >> LW);
    assign remain   = need_q - fill_cnt_q;
    assign take     = (remain > CW'(LANES)) ? CW'(LANES) : remain;

    // Only lanes below 'take' are consumed; a partial last beat drops its upper lanes.
    always_comb begin
        packed_next = dat_q;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (CW'(i) < take) begin
`ifdef PACKER_MLANE_LSB_FIRST_EN
                packed_next[(32'(fill_cnt_q) + i) * DATA_WIDTH +: DATA_WIDTH] =
                    bus.Dat[i*DATA_WIDTH +: DATA_WIDTH];
`else
                packed_next = {packed_next[PW-DATA_WIDTH-1:0], bus.Dat[i*DATA_WIDTH +: DATA_WIDTH]};
`endif
            end
        end
    end

    always_comb begin
        state_d           = state_q;
        need_d            = need_q;
        req_cnt_d         = req_cnt_q;
        fill_cnt_d        = fill_cnt_q;
        dat_d             = dat_q;
        bus.ReqDat        = 1'b0;
        bus.NearFnhPacker = 1'b0;
        case (state_q)
            IDLE: begin
                // A zero-length request finishes exactly like a bypass.
                if (bus.Bypass || (bus.Sta && need_in == '0)) begin
                    bus.NearFnhPacker = 1'b1;
                    dat_d             = '0;
                    state_d           = DONE;
                end else if (bus.Sta) begin
                    need_d     = need_in;
                    req_cnt_d  = '0;
                    fill_cnt_d = '0;
                    dat_d      = '0;
                    state_d    = FILL;
                end
            end
            FILL: begin
                bus.ReqDat = (req_cnt_q < beats);
                if (bus.ReqDat) begin
                    req_cnt_d = req_cnt_q + 1'b1;
                end
                if (bus.ValDat) begin
                    dat_d      = packed_next;
                    fill_cnt_d = fill_cnt_q + take;
                    if (fill_cnt_q + take == need_q) begin
                        bus.NearFnhPacker = 1'b1;
                        state_d           = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.OutRdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            need_q     <= '0;
            req_cnt_q  <= '0;
            fill_cnt_q <= '0;
            dat_q      <= '0;
        end else begin
            state_q    <= state_d;
            need_q     <= need_d;
            req_cnt_q  <= req_cnt_d;
            fill_cnt_q <= fill_cnt_d;
            dat_q      <= dat_d;
        end
    end

    assign bus.DatPacker = dat_q;
    assign bus.OutVal    = (state_q == DONE);
endmodule

// File: tb/tb_packer_mlane.sv
// Self-checking bench for packer_mlane: directed vectors, corner sequences and random runs.
module tb_packer_mlane;
    localparam int W  = 8;
    localparam int N  = 32;
    localparam int L  = 4;
    localparam int PW = W * N;
    localparam int CW = $clog2(N) + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    packer_mlane_if #(.DATA_WIDTH(W), .NUM_DATA(N), .LANES(L)) bus ();
    packer_mlane #(.DATA_WIDTH(W), .NUM_DATA(N), .LANES(L)) dut (.clk(clk), .rst(rst), .bus(bus));

    int    n_checks = 0;
    int    n_fail   = 0;
    string tag;

    logic [W*L-1:0] beat_mem [0:7];

    logic [PW-1:0] r_packed;
    int r_reqs, r_first_req, r_last_req, r_near_cyc, r_near_cnt, r_outval_cyc;
    bit r_stable, r_timeout, r_outval0;

    typedef struct {
        int          num;
        bit          byp;
        int          lat;
        int          stall;
        bit          inject;
        logic [31:0] b0;
        logic [31:0] b1;
        logic [63:0] exp;
        int          reqs;
    } vec_t;
    vec_t vecs [7];

    task automatic check_v(input string name, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: got %0h expected %0h", tag, name, got, exp);
        end
    endtask

    task automatic check_i(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s/%s: got %0d expected %0d", tag, name, got, exp);
        end
    endtask

    // Reference: the first n words of the beat stream laid out by word index.
    function automatic logic [PW-1:0] model_packed(input int num, input bit byp);
        logic [PW-1:0] acc;
        logic [W*L-1:0] b;
        int n;
        acc = '0;
        n = (num > N) ? N : num;
        if (byp) n = 0;
        for (int j = 0; j < n; j++) begin
            b = beat_mem[j / L];
`ifdef PACKER_MLANE_LSB_FIRST_EN
            acc[j*W +: W] = b[(j % L)*W +: W];
`else
            acc[(n-1-j)*W +: W] = b[(j % L)*W +: W];
`endif
        end
        return acc;
    endfunction

    function automatic int model_beats(input int num, input bit byp);
        int n;
        n = (num > N) ? N : num;
        if (byp) n = 0;
        return (n + L - 1) / L;
    endfunction

    // Drives one transaction starting just after a clock edge with the DUT idle.
    task automatic run_txn(input int num, input bit byp, input int lat, input int stall, input bit inject);
        int pend[$];
        int got;
        int cyc;
        bit done;
        got = 0; cyc = 0; done = 0;
        r_reqs = 0; r_first_req = -1; r_last_req = -1; r_near_cyc = -1; r_near_cnt = 0;
        r_outval_cyc = -1; r_stable = 1; r_timeout = 0; r_packed = '0; r_outval0 = 0;
        bus.NumPacker = CW'(num);
        bus.Sta       = !byp;
        bus.Bypass    = byp;
        while (!done) begin
            if (cyc > 0) begin
                bus.Sta    = inject && (r_outval_cyc >= 0);
                bus.Bypass = 1'b0;
                if (bus.Sta) bus.NumPacker = CW'($urandom_range(1, N));
            end
            if (pend.size() > 0 && pend[0] == cyc) begin
                void'(pend.pop_front());
                bus.ValDat = 1'b1;
                bus.Dat    = (got < 8) ? beat_mem[got] : $urandom;
                got++;
            end else begin
                bus.ValDat = 1'b0;
                bus.Dat    = $urandom;
            end
            bus.OutRdy = (stall == 0) || (r_outval_cyc >= 0 && cyc >= r_outval_cyc + stall);
            @(negedge clk);
            if (cyc == 0) r_outval0 = bus.OutVal;
            if (bus.ReqDat) begin
                r_reqs++;
                if (r_first_req < 0) r_first_req = cyc;
                r_last_req = cyc;
                pend.push_back(cyc + lat);
            end
            if (bus.NearFnhPacker) begin
                r_near_cnt++;
                r_near_cyc = cyc;
            end
            if (bus.OutVal) begin
                if (r_outval_cyc < 0) begin
                    r_outval_cyc = cyc;
                    r_packed     = bus.DatPacker;
                end else if (bus.DatPacker !== r_packed) begin
                    r_stable = 0;
                end
                if (bus.OutRdy) done = 1;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (cyc > 100) begin
                r_timeout = 1;
                done = 1;
            end
        end
        bus.Sta = 1'b0; bus.Bypass = 1'b0; bus.ValDat = 1'b0; bus.OutRdy = 1'b0;
        if (r_timeout) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
        end
    endtask

    task automatic check_txn(input logic [PW-1:0] exp, input int exp_reqs, input int lat);
        int exp_near;
        exp_near = (exp_reqs == 0) ? 0 : exp_reqs + lat;
        check_i("outval_at_start", int'(r_outval0), 0);
        check_i("timeout", int'(r_timeout), 0);
        check_v("packed", r_packed, exp);
        check_i("req_count", r_reqs, exp_reqs);
        if (exp_reqs > 0) begin
            check_i("req_first", r_first_req, 1);
            check_i("req_contig", r_last_req - r_first_req + 1, exp_reqs);
        end
        check_i("near_cycle", r_near_cyc, exp_near);
        check_i("near_count", r_near_cnt, 1);
        check_i("outval_cycle", r_outval_cyc, exp_near + 1);
        check_i("held_stable", int'(r_stable), 1);
    endtask

    initial begin
`ifdef PACKER_MLANE_LSB_FIRST_EN
        vecs[0] = '{8, 0, 1, 0, 0, 32'h04030201, 32'h08070605, 64'h0807060504030201, 2};
        vecs[1] = '{6, 0, 1, 0, 0, 32'h14131211, 32'hBBAA1615, 64'h0000161514131211, 2};
        vecs[4] = '{4, 0, 3, 0, 0, 32'hDDCCBBAA, 32'h99999999, 64'h00000000DDCCBBAA, 1};
        vecs[6] = '{5, 0, 2, 5, 1, 32'h04030201, 32'hEEDDCC05, 64'h0000000504030201, 2};
`else
        vecs[0] = '{8, 0, 1, 0, 0, 32'h04030201, 32'h08070605, 64'h0102030405060708, 2};
        vecs[1] = '{6, 0, 1, 0, 0, 32'h14131211, 32'hBBAA1615, 64'h0000111213141516, 2};
        vecs[4] = '{4, 0, 3, 0, 0, 32'hDDCCBBAA, 32'h99999999, 64'h00000000AABBCCDD, 1};
        vecs[6] = '{5, 0, 2, 5, 1, 32'h04030201, 32'hEEDDCC05, 64'h0000000102030405, 2};
`endif
        vecs[2] = '{5, 1, 1, 0, 0, 32'h12345678, 32'h9ABCDEF0, 64'h0, 0};
        vecs[3] = '{0, 0, 1, 0, 0, 32'h12345678, 32'h9ABCDEF0, 64'h0, 0};
        vecs[5] = '{1, 0, 1, 2, 0, 32'hFFFFFF77, 32'h55555555, 64'h77, 1};

        bus.Sta = 0; bus.Bypass = 0; bus.NumPacker = '0; bus.ValDat = 0; bus.Dat = '0; bus.OutRdy = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        tag = "reset";
        @(negedge clk);
        check_v("DatPacker", bus.DatPacker, '0);
        check_i("OutVal", int'(bus.OutVal), 0);
        check_i("ReqDat", int'(bus.ReqDat), 0);
        check_i("NearFnhPacker", int'(bus.NearFnhPacker), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            tag = $sformatf("vec%0d", i);
            beat_mem[0] = vecs[i].b0;
            beat_mem[1] = vecs[i].b1;
            for (int k = 2; k < 8; k++) beat_mem[k] = '0;
            run_txn(vecs[i].num, vecs[i].byp, vecs[i].lat, vecs[i].stall, vecs[i].inject);
            check_txn(PW'(vecs[i].exp), vecs[i].reqs, vecs[i].lat);
        end

        tag = "full32";
        for (int k = 0; k < 8; k++) beat_mem[k] = {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)};
        run_txn(32, 0, 1, 0, 0);
        check_txn(model_packed(32, 0), 8, 1);
        check_i("outval_at_sta_plus_10", r_outval_cyc, 10);

        tag = "reset_mid";
        for (int k = 0; k < 8; k++) beat_mem[k] = $urandom;
        bus.NumPacker = CW'(32);
        bus.Sta = 1'b1;
        @(posedge clk); #1;
        bus.Sta = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            bus.ValDat = 1'b1;
            bus.Dat    = beat_mem[i];
            @(posedge clk); #1;
        end
        rst = 1'b1;
        bus.ValDat = 1'b1;
        bus.Dat    = $urandom;
        @(negedge clk);
        check_v("partial_fill", bus.DatPacker, model_packed(12, 0));
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.ValDat = 1'b1;
            bus.Dat    = $urandom;
            @(negedge clk);
            check_v("cleared_DatPacker", bus.DatPacker, '0);
            check_i("cleared_OutVal", int'(bus.OutVal), 0);
            check_i("cleared_ReqDat", int'(bus.ReqDat), 0);
            check_i("cleared_Near", int'(bus.NearFnhPacker), 0);
            @(posedge clk); #1;
        end
        bus.ValDat = 1'b0;
        tag = "after_reset";
        for (int k = 0; k < 8; k++) beat_mem[k] = $urandom;
        run_txn(4, 0, 1, 0, 0);
        check_txn(model_packed(4, 0), 1, 1);

        for (int t = 0; t < 30; t++) begin
            int num, lat, stall;
            bit byp;
            tag   = $sformatf("rand%0d", t);
            num   = $urandom_range(0, 40);
            byp   = ($urandom_range(0, 7) == 0);
            lat   = $urandom_range(1, 3);
            stall = $urandom_range(0, 3);
            for (int k = 0; k < 8; k++) beat_mem[k] = $urandom;
            run_txn(num, byp, lat, stall, stall > 1);
            check_txn(model_packed(num, byp), model_beats(num, byp), lat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
